// File: rtl/clock_alarm_pkg.sv
// Shared types, limits and BCD helpers for the clock/alarm controller.
// The ALARM_AUTO_OFF_EN build option is consumed by clock_alarm_ctrl.
package clock_alarm_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        SET_TIME  = 2'd1,
        SET_ALARM = 2'd2,
        RINGING   = 2'd3
    } state_t;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t hour_1;
        bcd_t hour_2;
        bcd_t min_1;
        bcd_t min_2;
        bcd_t sec_1;
        bcd_t sec_2;
    } hms_t;

    localparam int HOUR_MAX = 23;
    localparam int MIN_MAX  = 59;

    function automatic logic [7:0] to_bcd8(input int value);
        return {4'(value / 10), 4'(value % 10)};
    endfunction

    // Two-digit BCD increment {tens, ones} that wraps to 00 after max_value.
    function automatic logic [7:0] bcd_inc_wrap(input logic [7:0] value, input int max_value);
        if (value == to_bcd8(max_value)) begin
            return 8'h00;
        end
        if (value[3:0] == 4'd9) begin
            return {value[7:4] + 4'd1, 4'd0};
        end
        return {value[7:4], value[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/clock_alarm_ctrl_bcd_time_counter.sv
// hh:mm:ss BCD time-of-day counter: advances on tick, synchronous hh:mm load
// clears the seconds. time_next exposes the value the register takes next edge.
module bcd_time_counter
    import clock_alarm_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic load,
    input  logic [3:0] load_hour_1,
    input  logic [3:0] load_hour_2,
    input  logic [3:0] load_min_1,
    input  logic [3:0] load_min_2,
    output hms_t time_q,
    output hms_t time_next
);

    logic [7:0] sec_q;
    logic [7:0] min_q;
    logic [7:0] hour_q;

    assign sec_q  = {time_q.sec_1, time_q.sec_2};
    assign min_q  = {time_q.min_1, time_q.min_2};
    assign hour_q = {time_q.hour_1, time_q.hour_2};

    // A load takes precedence over a coincident tick.
    always_comb begin
        time_next = time_q;
        if (load) begin
            time_next.hour_1 = load_hour_1;
            time_next.hour_2 = load_hour_2;
            time_next.min_1  = load_min_1;
            time_next.min_2  = load_min_2;
            time_next.sec_1  = 4'd0;
            time_next.sec_2  = 4'd0;
        end else if (tick) begin
            {time_next.sec_1, time_next.sec_2} = bcd_inc_wrap(sec_q, MIN_MAX);
            if (sec_q == to_bcd8(MIN_MAX)) begin
                {time_next.min_1, time_next.min_2} = bcd_inc_wrap(min_q, MIN_MAX);
                if (min_q == to_bcd8(MIN_MAX)) begin
                    {time_next.hour_1, time_next.hour_2} = bcd_inc_wrap(hour_q, HOUR_MAX);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            time_q <= '0;
        end else begin
            time_q <= time_next;
        end
    end

endmodule

// File: rtl/clock_alarm_ctrl.sv
// Mode/timekeeping controller: button FSM, edit and alarm registers, alarm compare,
// registered display and LEDs. Define ALARM_AUTO_OFF_EN for the ringing timeout.
module clock_alarm_ctrl
    import clock_alarm_pkg::*;
#(
    parameter int RING_TIMEOUT_S = 60
)
(
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic       tick_1hz,
    input  logic       set_mode_button,
    input  logic       inc_hour_button,
    input  logic       inc_min_button,
    input  logic       confirm_button,
    output logic [3:0] hour_1,
    output logic [3:0] hour_2,
    output logic [3:0] min_1,
    output logic [3:0] min_2,
    output logic [3:0] sec_1,
    output logic [3:0] sec_2,
    output logic [7:0] leds,
    output logic       ring
);

    if (RING_TIMEOUT_S < 1) begin : g_bad_timeout
        $error("RING_TIMEOUT_S must be at least 1");
    end

    state_t     state, state_n;
    logic [3:0] btn_now, btn_prev, press;
    logic       press_set, press_confirm, press_hour, press_min;
    logic [7:0] edit_hour, edit_hour_n, edit_min, edit_min_n;
    logic [7:0] alarm_hour, alarm_hour_n, alarm_min, alarm_min_n;
    logic       alarm_en, alarm_en_n;
    logic       load_time, alarm_match, ring_timeout;
    hms_t       time_q, time_next;

    // Only the highest-priority new press in a cycle is acted on.
    assign btn_now       = {set_mode_button, confirm_button, inc_hour_button, inc_min_button};
    assign press         = btn_now & ~btn_prev;
    assign press_set     = press[3];
    assign press_confirm = press[2] & ~press[3];
    assign press_hour    = press[1] & ~(|press[3:2]);
    assign press_min     = press[0] & ~(|press[3:1]);

    assign alarm_match = (state == RUN) && alarm_en
                      && ({time_q.hour_1, time_q.hour_2} == alarm_hour)
                      && ({time_q.min_1, time_q.min_2} == alarm_min)
                      && ({time_q.sec_1, time_q.sec_2} == 8'h00);

    bcd_time_counter u_time (
        .clk         (clk_clk),
        .rst         (reset_reset),
        .tick        (tick_1hz),
        .load        (load_time),
        .load_hour_1 (edit_hour[7:4]),
        .load_hour_2 (edit_hour[3:0]),
        .load_min_1  (edit_min[7:4]),
        .load_min_2  (edit_min[3:0]),
        .time_q      (time_q),
        .time_next   (time_next)
    );

`ifdef ALARM_AUTO_OFF_EN
    localparam int RING_CNT_W = $clog2(RING_TIMEOUT_S + 2);
    logic [RING_CNT_W-1:0] ring_cnt;

    // Cleared whenever not ringing, so each RINGING entry starts from zero.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            ring_cnt <= '0;
        end else if (state != RINGING) begin
            ring_cnt <= '0;
        end else if (tick_1hz) begin
            ring_cnt <= ring_cnt + 1'b1;
        end
    end

    assign ring_timeout = (ring_cnt == RING_CNT_W'(RING_TIMEOUT_S));
`else
    assign ring_timeout = 1'b0;
`endif

    always_comb begin
        state_n      = state;
        edit_hour_n  = edit_hour;
        edit_min_n   = edit_min;
        alarm_hour_n = alarm_hour;
        alarm_min_n  = alarm_min;
        alarm_en_n   = alarm_en;
        load_time    = 1'b0;
        unique case (state)
            RUN: begin
                if (alarm_match) begin
                    state_n = RINGING;
                end else if (press_set) begin
                    state_n     = SET_TIME;
                    edit_hour_n = {time_q.hour_1, time_q.hour_2};
                    edit_min_n  = {time_q.min_1, time_q.min_2};
                end else if (press_confirm) begin
                    alarm_en_n = ~alarm_en;
                end
            end
            SET_TIME, SET_ALARM: begin
                if (press_set) begin
                    if (state == SET_TIME) begin
                        state_n     = SET_ALARM;
                        edit_hour_n = alarm_hour;
                        edit_min_n  = alarm_min;
                    end else begin
                        state_n = RUN;
                    end
                end else if (press_confirm) begin
                    state_n = RUN;
                    if (state == SET_TIME) begin
                        load_time = 1'b1;
                    end else begin
                        alarm_hour_n = edit_hour;
                        alarm_min_n  = edit_min;
                        alarm_en_n   = 1'b1;
                    end
                end else if (press_hour) begin
                    edit_hour_n = bcd_inc_wrap(edit_hour, HOUR_MAX);
                end else if (press_min) begin
                    edit_min_n = bcd_inc_wrap(edit_min, MIN_MAX);
                end
            end
            RINGING: begin
                if (press_confirm || ring_timeout) begin
                    state_n = RUN;
                end
            end
            default: state_n = RUN;
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state      <= RUN;
            btn_prev   <= 4'hF;
            edit_hour  <= 8'h00;
            edit_min   <= 8'h00;
            alarm_hour <= 8'h00;
            alarm_min  <= 8'h00;
            alarm_en   <= 1'b0;
        end else begin
            state      <= state_n;
            btn_prev   <= btn_now;
            edit_hour  <= edit_hour_n;
            edit_min   <= edit_min_n;
            alarm_hour <= alarm_hour_n;
            alarm_min  <= alarm_min_n;
            alarm_en   <= alarm_en_n;
        end
    end

    // Outputs are registered from next-state values so they track the state with no extra lag.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            {hour_1, hour_2, min_1, min_2, sec_1, sec_2} <= '0;
            leds <= 8'h00;
            ring <= 1'b0;
        end else begin
            if (state_n == SET_TIME || state_n == SET_ALARM) begin
                {hour_1, hour_2} <= edit_hour_n;
                {min_1, min_2}   <= edit_min_n;
                {sec_1, sec_2}   <= 8'h00;
            end else begin
                {hour_1, hour_2, min_1, min_2, sec_1, sec_2} <= time_next;
            end
            leds <= {4'b0000, state_n == RINGING, state_n == SET_ALARM,
                     state_n == SET_TIME, alarm_en_n};
            ring <= (state_n == RINGING);
        end
    end

endmodule

// File: tb/tb_clock_alarm_ctrl.sv
// Scoreboard bench for clock_alarm_ctrl: an integer-seconds reference model predicts
// every registered output; directed anchors plus randomized buttons/ticks/resets.
module tb_clock_alarm_ctrl;

    localparam int TIMEOUT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b0;
    logic b_set = 1'b0, b_hour = 1'b0, b_min = 1'b0, b_conf = 1'b0;
    logic [3:0] hour_1, hour_2, min_1, min_2, sec_1, sec_2;
    logic [7:0] leds;
    logic       ring;

    clock_alarm_ctrl #(.RING_TIMEOUT_S(TIMEOUT)) dut (
        .clk_clk         (clk),
        .reset_reset     (rst),
        .tick_1hz        (tick),
        .set_mode_button (b_set),
        .inc_hour_button (b_hour),
        .inc_min_button  (b_min),
        .confirm_button  (b_conf),
        .hour_1          (hour_1),
        .hour_2          (hour_2),
        .min_1           (min_1),
        .min_2           (min_2),
        .sec_1           (sec_1),
        .sec_2           (sec_2),
        .leds            (leds),
        .ring            (ring)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 run, 1 set time, 2 set alarm, 3 ringing.
    int m_mode, m_time, m_alarm, m_eh, m_em, m_cnt;
    bit m_en;
    bit [3:0] m_prev;
    logic [32:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [32:0] pack_out(int hh, int mm, int ss, logic [7:0] l, logic r);
        return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10),
                4'(ss / 10), 4'(ss % 10), l, r};
    endfunction

    function automatic logic [32:0] dut_out();
        return {hour_1, hour_2, min_1, min_2, sec_1, sec_2, leds, ring};
    endfunction

    function automatic logic [32:0] model_out();
        logic [7:0] l;
        l = {4'b0000, m_mode == 3, m_mode == 2, m_mode == 1, m_en};
        if (m_mode == 1 || m_mode == 2) return pack_out(m_eh, m_em, 0, l, 1'b0);
        return pack_out(m_time / 3600, (m_time / 60) % 60, m_time % 60, l, m_mode == 3);
    endfunction

    task automatic model_step(bit r, bit s, bit c, bit h, bit m, bit t);
        bit [3:0] lv, pr;
        bit p_set, p_conf, p_hr, p_mn, match, auto_off;
        int old_t, old_mode, new_t;
        if (r) begin
            m_mode = 0; m_time = 0; m_alarm = 0; m_eh = 0; m_em = 0;
            m_en = 0; m_prev = 4'hF; m_cnt = 0;
            return;
        end
        lv = {s, c, h, m};
        pr = lv & ~m_prev;
        m_prev = lv;
        p_set  = pr[3];
        p_conf = pr[2] && !pr[3];
        p_hr   = pr[1] && pr[3:2] == 2'b00;
        p_mn   = pr[0] && pr[3:1] == 3'b000;
        old_t = m_time;
        old_mode = m_mode;
        new_t = t ? (old_t + 1) % 86400 : old_t;
        match = (m_mode == 0) && m_en && (old_t == m_alarm * 60);
`ifdef ALARM_AUTO_OFF_EN
        auto_off = (m_cnt == TIMEOUT);
`else
        auto_off = 1'b0;
`endif
        case (m_mode)
            0: begin
                if (match) m_mode = 3;
                else if (p_set) begin m_mode = 1; m_eh = old_t / 3600; m_em = (old_t / 60) % 60; end
                else if (p_conf) m_en = !m_en;
            end
            1, 2: begin
                if (p_set) begin
                    if (m_mode == 1) begin m_mode = 2; m_eh = m_alarm / 60; m_em = m_alarm % 60; end
                    else m_mode = 0;
                end else if (p_conf) begin
                    if (m_mode == 1) new_t = m_eh * 3600 + m_em * 60;
                    else begin m_alarm = m_eh * 60 + m_em; m_en = 1; end
                    m_mode = 0;
                end else if (p_hr) m_eh = (m_eh + 1) % 24;
                else if (p_mn) m_em = (m_em + 1) % 60;
            end
            default: if (p_conf || auto_off) m_mode = 0;
        endcase
        if (old_mode != 3) m_cnt = 0;
        else if (t) m_cnt++;
        m_time = new_t;
    endtask

    task automatic applyStimulus(bit r, bit s, bit c, bit h, bit m, bit t);
        @(negedge clk);
        rst = r; b_set = s; b_conf = c; b_hour = h; b_min = m; tick = t;
        model_step(r, s, c, h, m, t);
        exp_q.push_back(model_out());
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0);
    endtask

    task automatic pressButton(int which);
        applyStimulus(0, which == 0, which == 1, which == 2, which == 3, 0);
        idle();
    endtask

    task automatic tickN(int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 1);
            idle();
        end
    endtask

    task automatic editTo(int h, int m);
        int nh, nm;
        nh = (h - m_eh + 24) % 24;
        nm = (m - m_em + 60) % 60;
        for (int i = 0; i < nh; i++) pressButton(2);
        for (int i = 0; i < nm; i++) pressButton(3);
        pressButton(1);
    endtask

    task automatic setTimeTo(int h, int m);
        pressButton(0);
        editTo(h, m);
    endtask

    task automatic setAlarmTo(int h, int m);
        pressButton(0);
        pressButton(0);
        editTo(h, m);
    endtask

    // Anchor against constants derived by hand, sampled after the last applied edge.
    task automatic checkOutput(string name, int hh, int mm, int ss, logic [7:0] l, logic r);
        logic [32:0] want;
        @(posedge clk);
        #2;
        want = pack_out(hh, mm, ss, l, r);
        checks++;
        if (dut_out() !== want) begin
            errors++;
            $display("[TB] FAIL %s got=%h want=%h", name, dut_out(), want);
        end
    endtask

    // Monitor: one expected output per applied cycle, compared just after the edge.
    always @(posedge clk) begin
        logic [32:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (dut_out() !== e) begin
                errors++;
                $display("[TB] FAIL scoreboard t=%0t got=%h want=%h", $time, dut_out(), e);
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("reset", 0, 0, 0, 8'h00, 0);
        idle();
        tickN(3);
        checkOutput("three_ticks", 0, 0, 3, 8'h00, 0);

        setTimeTo(23, 59);
        tickN(58);
        checkOutput("preset_2359", 23, 59, 58, 8'h00, 0);
        tickN(2);
        checkOutput("midnight_wrap", 0, 0, 0, 8'h00, 0);

        applyStimulus(0, 1, 0, 0, 0, 0);
        checkOutput("enter_set_time", 0, 0, 0, 8'h02, 0);
        idle();
        for (int i = 0; i < 25; i++) pressButton(2);
        for (int i = 0; i < 61; i++) pressButton(3);
        checkOutput("edit_wrap", 1, 1, 0, 8'h02, 0);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("time_loaded", 1, 1, 0, 8'h00, 0);
        idle();

        setAlarmTo(7, 30);
        checkOutput("alarm_armed", 1, 1, 0, 8'h01, 0);
        setTimeTo(7, 29);
        tickN(58);
        applyStimulus(0, 0, 0, 0, 0, 1);
        idle();
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("ring_not_yet", 7, 30, 0, 8'h01, 0);
        idle();
        checkOutput("ring_rises", 7, 30, 0, 8'h09, 1);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("ring_confirm", 7, 30, 0, 8'h01, 0);
        idle();
        checkOutput("ring_again_same_second", 7, 30, 0, 8'h09, 1);
        applyStimulus(0, 1, 0, 1, 1, 0);
        checkOutput("ringing_ignores_set", 7, 30, 0, 8'h09, 1);
        idle();

`ifdef ALARM_AUTO_OFF_EN
        tickN(4);
        checkOutput("auto_off", 7, 30, 4, 8'h01, 0);
        applyStimulus(0, 1, 0, 0, 1, 0);
        checkOutput("set_beats_min", 7, 30, 0, 8'h03, 0);
`else
        tickN(100);
        checkOutput("no_auto_off", 7, 31, 40, 8'h09, 1);
        pressButton(1);
        applyStimulus(0, 1, 0, 0, 1, 0);
        checkOutput("set_beats_min", 7, 31, 0, 8'h03, 0);
`endif
        idle();
        pressButton(0);
        checkOutput("set_alarm_shows_alarm", 7, 30, 0, 8'h05, 0);
        pressButton(0);
        pressButton(0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("reset_mid_edit", 0, 0, 0, 8'h00, 0);
        idle();

        setAlarmTo(0, 1);
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 1499) == 0,
                          $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                          $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                          $urandom_range(0, 2) == 0);
        end
        idle();
        @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
